// File: rtl/simd_gpu_core.sv
// 4-lane SIMD integer execution unit: lane-wise ADD/MUL/SUB/AND on 32-bit
// unsigned elements with a single registered 128-bit result.
module simd_gpu_core #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               instruction,
  input  logic [LANES*LANE_W-1:0]   src_a,
  input  logic [LANES*LANE_W-1:0]   src_b,
  output logic [LANES*LANE_W-1:0]   result
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  // Everything is modulo 2^LANE_W: operands and result share one width, so
  // carries, borrows and the high product half fall off naturally.
  function automatic logic [LANE_W-1:0] lane_alu(
    input logic [1:0]        op,
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b
  );
    logic [LANE_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_MUL:  r = a * b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]              op_p0;
  logic [LANES*LANE_W-1:0] alu_p0;
  logic [LANES*LANE_W-1:0] result_p1;
  logic                    unused_instr_bits;

  assign op_p0             = instruction[15:14];
  assign unused_instr_bits = ^instruction[13:0];

  // Stage 0: independent combinational ALU per lane
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign alu_p0[i*LANE_W +: LANE_W] =
      lane_alu(op_p0, src_a[i*LANE_W +: LANE_W], src_b[i*LANE_W +: LANE_W]);
  end

  // Stage 1: result register, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_p1 <= '0;
    end else begin
      result_p1 <= alu_p0;
    end
  end

  assign result = result_p1;

endmodule

// File: tb/tb_simd_gpu_core.sv
// Bench for simd_gpu_core: directed cases plus random traffic against a
// modular-arithmetic reference model.
module tb_simd_gpu_core;

  logic         clk;
  logic         reset;
  logic [15:0]  instruction;
  logic [127:0] src_a;
  logic [127:0] src_b;
  logic [127:0] result;

  int checks = 0;
  int errors = 0;

  logic [127:0] pend_exp;
  string        pend_tag;
  bit           pend_vld = 0;

  simd_gpu_core #(.LANES(4), .LANE_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .src_a(src_a),
    .src_b(src_b),
    .result(result)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_vec(input logic [15:0] ins,
                                           input logic [127:0] a,
                                           input logic [127:0] b);
    longint unsigned m, x, y, r;
    logic [127:0] v;
    m = 64'h1_0000_0000;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      x = 64'(a[32*i +: 32]);
      y = 64'(b[32*i +: 32]);
      case (ins[15:14])
        2'd0:    r = (x + y) % m;
        2'd1:    r = (x * y) % m;
        2'd2:    r = (x + m - y) % m;
        default: r = x & y;
      endcase
      v[32*i +: 32] = r[31:0];
    end
    return v;
  endfunction

  function automatic logic [127:0] vec4(input logic [31:0] l3, input logic [31:0] l2,
                                        input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] exp);
    checks++;
    assert (result === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, result, exp);
      end
  endtask

  // Drive one operation at a falling edge; the previous one is checked first.
  task automatic step(input string tag, input logic [15:0] ins,
                      input logic [127:0] a, input logic [127:0] b);
    @(negedge clk);
    if (pend_vld) check(pend_tag, pend_exp);
    instruction = ins;
    src_a       = a;
    src_b       = b;
    pend_exp    = ref_vec(ins, a, b);
    pend_tag    = tag;
    pend_vld    = 1;
  endtask

  task automatic flush();
    @(negedge clk);
    if (pend_vld) check(pend_tag, pend_exp);
    pend_vld = 0;
  endtask

  logic [127:0] a_v, b_v, and_exp;
  logic [15:0]  ins_v;

  initial begin
    reset       = 1;
    instruction = 16'h0000;
    src_a       = rand128();
    src_b       = rand128();
    #2 reset = 0;
    #1 check("reset_async", 128'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instruction = 16'($urandom);
      src_a       = rand128();
      src_b       = rand128();
      check("reset_hold", 128'h0);
    end

    // Release reset together with the first operation
    step("add_basic", 16'h0000, vec4(4, 3, 2, 1), vec4(40, 30, 20, 10));
    reset = 1;
    pend_exp = vec4(44, 33, 22, 11);
    step("mul_basic", 16'h4000, vec4(4, 3, 2, 1), vec4(5, 6, 7, 8));
    pend_exp = vec4(20, 18, 14, 8);
    step("mul_trunc", 16'h4000, vec4(7, 9, 3, 32'h0001_0000),
         vec4(2, 2, 2, 32'h0001_0000));
    pend_exp = vec4(14, 18, 6, 0);
    step("add_wrap", 16'h0000, vec4(0, 0, 5, 32'hFFFF_FFFF), vec4(0, 0, 6, 1));
    pend_exp = vec4(0, 0, 11, 0);
    step("sub_borrow", 16'h8000, vec4(9, 8, 7, 0), vec4(1, 1, 1, 1));
    pend_exp = vec4(8, 7, 6, 32'hFFFF_FFFF);
    a_v     = {4{32'hF0F0_F0F0}};
    b_v     = {4{32'hFF00_FF00}};
    and_exp = {4{32'hF000_F000}};
    step("and_basic", 16'hC000, a_v, b_v);
    pend_exp = and_exp;
    step("and_resv", 16'hFFFF, a_v, b_v);
    pend_exp = and_exp;
    step("add_resv", 16'h3FFF, vec4(1, 2, 3, 4), vec4(10, 20, 30, 40));
    pend_exp = vec4(11, 22, 33, 44);
    // Back-to-back ADD then MUL
    step("b2b_add", 16'h0000, vec4(100, 200, 300, 400), vec4(1, 2, 3, 4));
    step("b2b_mul", 16'h4000, vec4(100, 200, 300, 400), vec4(1, 2, 3, 4));
    flush();

    for (int n = 0; n < 40; n++) begin
      ins_v = 16'($urandom);
      step("random", ins_v, rand128(), rand128());
    end

    // Reset pulse mid-stream
    step("pre_reset", 16'h4000, rand128(), rand128());
    @(posedge clk);
    #2 reset = 0;
    #1 check("reset_mid_async", 128'h0);
    pend_vld = 0;
    @(posedge clk);
    #1 check("reset_mid_hold", 128'h0);
    @(negedge clk);
    reset    = 1;
    pend_exp = ref_vec(instruction, src_a, src_b);
    pend_tag = "post_reset";
    pend_vld = 1;
    step("post_reset2", 16'h8000, rand128(), rand128());
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
